wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
- Wishbone B3 initiator that drives the SDRAM controller's Wishbone slave port (wb_stb/wb_cyc/wb_cti/wb_ack).
- Converts a simple command stream into single or incrementing-burst Wishbone cycles, with write-data and read-data streams on the user side.
- Sits in the wb_clk_i domain, between a DMA/traffic source and the SDRAM controller's Wishbone slave.
- Includes an ack timeout so the bench and system never hang.

Parameters:
- AW, 26: Wishbone byte address width.
- DW, 32: data width; SEL width is DW/8.
- LW, 9: burst length field width, in beats.
- TMO_W, 8: timeout counter width. The timeout fires after 2^TMO_W-1 cycles without ack.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AW  start byte address, DW/8 aligned.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_len  in  LW  beats, 1..2^LW-1.
- cmd_sel  in  DW/8  byte enables applied to every beat.
- wr_valid  in  1  write data present.
- wr_ready  out  1  write data accepted.
- wr_data  in  DW  write beat.
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure.
- rd_data  out  DW  read beat.
- done  out  1  one-cycle pulse at end of a command.
- err  out  1  qualifies done; 1 = timed out.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_addr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  Wishbone byte select.
- wb_cti_o  out  3  Wishbone cycle type.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_dat_i  in  DW  Wishbone read data.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. wb_cti_o=3'b000. State=IDLE.
- States: IDLE, WLOAD, XFER, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr, we, len, sel.
  - beats_left = cmd_len.
  - cmd_len==0 is a legal no-op: go to DONE with err=0, no Wishbone cycle.
  - Write command → WLOAD. Read command → XFER with cyc=stb=1.
- WLOAD:
  - wr_ready=1. On wr_valid, wb_dat_o <= wr_data, then XFER.
  - wb_cyc_o is held high across WLOAD once the burst has started; stb stays low while waiting for data (legal Wishbone wait).
- XFER:
  - stb=1, and the outputs are held stable until ack.
  - wb_cti_o = 3'b111 when beats_left==1, else 3'b010 (incrementing).
  - On wb_ack_i:
    - addr += DW/8, wrapping modulo 2^AW.
    - beats_left -= 1.
    - On reads, rd_valid=1 and rd_data=wb_dat_i, registered, so they appear 1 cycle after ack.
  - If the beat just acked was the last: drop cyc/stb the same edge and go to DONE.
  - Otherwise a write returns to WLOAD and a read stays in XFER.
  - Back-to-back acks must sustain 1 beat/cycle for reads.
  - Writes sustain 1 beat/cycle only if wr_valid is already high. In that case WLOAD is skipped: wr_ready is asserted combinationally with ack, and wb_dat_o is loaded on the same edge.
- Timeout:
  - A counter resets on every ack or state entry and counts while stb=1 and ack=0.
  - On reaching 2^TMO_W-1: deassert cyc/stb, go to DONE with err=1, and discard the remaining beats.
  - On write timeout the remaining wr data is NOT consumed; the source must flush it.
- DONE: one cycle with done=1 and err as recorded, then IDLE. cmd_ready=0 in DONE.
- No new command is accepted while a command is active, so at most one outstanding command.
- wb_sel_o = latched sel for the whole command. wb_we_o is constant during a cycle.
- Reset mid-burst: all outputs return to reset values immediately (async); the partial burst is abandoned.
- A late ack while cyc=0 is ignored.

Decomposition:
- Shared package wb_master_pkg holds:
  - state encoding localparams;
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - timeout max.
- One natural sub-module: wb_ack_timer, holding the timeout counter with clear, enable and expired outputs.

Test Plan:
- Single write: cmd addr=0x100, we=1, len=1, sel=4'hF, wr_data=0xDEADBEEF; slave acks after 2 cycles → one stb cycle, cti=111, wb_dat_o=0xDEADBEEF, done=1, err=0.
- Read burst: addr=0x200, len=4; slave acks every cycle with 0x11,0x22,0x33,0x44 → addresses 0x200/204/208/20C, cti 010,010,010,111, four rd_valid pulses in order, done after the last beat.
- Write burst with gaps: len=3, wr_valid low for 2 cycles before beat 2 → stb drops and cyc stays high during the gap; data order preserved; cti=111 only on beat 3.
- Timeout: TMO_W=4, read len=2, slave never acks → cyc/stb fall after 15 cycles, done=1, err=1, no rd_valid.
- Address wrap: AW=26, addr=0x3FFFFFC, len=2 → second beat at 0x0000000.
- Async reset asserted mid-burst on beat 2 of 4 → cyc, stb and done=0 immediately, cmd_ready=1 after release, and a new command completes normally.

Source files
------------

// File: rtl/wb_burst_master_pkg.sv
// wb_master_pkg: shared state encoding, CTI codes and timeout helpers for wb_burst_master.
package wb_master_pkg;
  typedef enum logic [1:0] {IDLE, WLOAD, XFER, DONE} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  function automatic int tmo_max(int w);
    return (1 << w) - 1;
  endfunction
  function automatic logic [2:0] cti_of(logic last);
    return last ? CTI_EOB : CTI_INCR;
  endfunction
endpackage

// File: rtl/wb_burst_master_if.sv
// wb_burst_master_if: Wishbone B3 bus between the burst master and the SDRAM controller slave.
interface wb_burst_master_if #(parameter int AW = 26, parameter int DW = 32);
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0] wb_cti_o;
  modport master(output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                 input wb_ack_i, wb_dat_i);
  modport slave(input wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                output wb_ack_i, wb_dat_i);
endinterface

// File: rtl/wb_burst_master_ack_timer.sv
// wb_ack_timer: counts strobe cycles without ack; expired marks the last tolerated cycle.
module wb_ack_timer
  import wb_master_pkg::*;
#(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  assign expired = en && cnt == W'(tmo_max(W) - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: turns a command stream into single/incrementing-burst Wishbone B3 cycles.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int AW = 26,
  parameter int DW = 32,
  parameter int LW = 9,
  parameter int TMO_W = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic cmd_we,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic rd_valid,
  output logic [DW-1:0] rd_data,
  output logic done,
  output logic err,
  wb_burst_master_if.master wb
);
  state_t state;
  logic [LW-1:0] beats;
  logic ack, last, expired;
  assign ack = state == XFER && wb.wb_ack_i;
  assign last = beats == LW'(1);
  // wr_ready rides on ack so a ready source streams one write beat per cycle
  assign wr_ready = state == WLOAD || (ack && wb.wb_we_o && !last);
  wb_ack_timer #(.W(TMO_W)) u_timer (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clr(!wb.wb_stb_o || wb.wb_ack_i),
    .en(wb.wb_stb_o && !wb.wb_ack_i),
    .expired(expired)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      beats <= '0;
      done <= 1'b0;
      err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o <= 1'b0;
      wb.wb_addr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      wb.wb_cti_o <= CTI_CLASSIC;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          wb.wb_addr_o <= cmd_addr;
          wb.wb_we_o <= cmd_we;
          wb.wb_sel_o <= cmd_sel;
          beats <= cmd_len;
          if (cmd_len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (cmd_we) state <= WLOAD;
          else begin
            state <= XFER;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_cti_o <= cti_of(cmd_len == LW'(1));
          end
        end
        WLOAD: if (wr_valid) begin
          state <= XFER;
          wb.wb_dat_o <= wr_data;
          wb.wb_cyc_o <= 1'b1;
          wb.wb_stb_o <= 1'b1;
          wb.wb_cti_o <= cti_of(last);
        end
        XFER: if (ack) begin
          wb.wb_addr_o <= wb.wb_addr_o + AW'(DW / 8);
          beats <= beats - 1'b1;
          rd_valid <= !wb.wb_we_o;
          if (!wb.wb_we_o) rd_data <= wb.wb_dat_i;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_cti_o <= CTI_CLASSIC;
          end else if (wb.wb_we_o && !wr_valid) begin
            state <= WLOAD;
            wb.wb_stb_o <= 1'b0;
          end else begin
            if (wb.wb_we_o) wb.wb_dat_o <= wr_data;
            wb.wb_cti_o <= cti_of(beats == LW'(2));
          end
        end else if (expired) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b1;
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
          wb.wb_cti_o <= CTI_CLASSIC;
        end
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed checks of wb_burst_master against a simple delayed-ack slave.
module tb_wb_burst_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [8:0] cmd_len = '0;
  logic [3:0] cmd_sel = '0;
  logic wr_valid, wr_ready, rd_valid, done, err;
  logic [31:0] wr_data, rd_data;
  wb_burst_master_if #(.AW(26), .DW(32)) bus();
  wb_burst_master #(.AW(26), .DW(32), .LW(9), .TMO_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
    .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .wb(bus)
  );
  int n_cmp = 0, n_bad = 0;
  int delay = 0;
  logic noack = 1'b0, clr = 1'b0;
  logic [3:0] wcnt = '0;
  logic [2:0] ridx = '0;
  logic [31:0] rdat [8];
  logic [31:0] wdat [8];
  int wgap [8];
  int wn = 0;
  assign bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && !noack && int'(wcnt) >= delay;
  assign bus.wb_dat_i = rdat[ridx];
  always @(posedge clk) begin
    wcnt <= (bus.wb_stb_o && !bus.wb_ack_i) ? wcnt + 4'd1 : 4'd0;
    ridx <= clr ? 3'd0 : bus.wb_ack_i ? ridx + 3'd1 : ridx;
  end
  int nb, nr, nstb, ngap, ndone;
  logic lerr;
  logic [25:0] b_addr [8];
  logic [2:0] b_cti [8];
  logic [31:0] b_dat [8], r_dat [8];
  logic [3:0] b_sel [8];
  always @(negedge clk)
    if (clr) begin
      nb = 0; nr = 0; nstb = 0; ngap = 0; ndone = 0; lerr = 1'b0;
    end else begin
      if (bus.wb_ack_i && nb < 8) begin
        b_addr[nb] = bus.wb_addr_o; b_cti[nb] = bus.wb_cti_o;
        b_dat[nb] = bus.wb_dat_o; b_sel[nb] = bus.wb_sel_o; nb++;
      end
      if (rd_valid && nr < 8) begin r_dat[nr] = rd_data; nr++; end
      if (bus.wb_stb_o) nstb++;
      if (bus.wb_cyc_o && !bus.wb_stb_o) ngap++;
      if (done) begin ndone++; lerr = err; end
    end
  initial begin
    int widx, gcnt;
    logic hs, sclr;
    widx = 0; gcnt = 0;
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      sclr = clr;
      @(posedge clk); #1;
      if (sclr) begin widx = 0; gcnt = 0; end
      else if (hs) begin widx++; gcnt = 0; end
      else if (!wr_valid) gcnt++;
      wr_valid = widx < wn && widx < 8 && gcnt >= wgap[widx % 8];
      wr_data = wdat[widx % 8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start_log();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask
  task automatic issue(input logic [25:0] a, input logic we, input logic [8:0] len);
    start_log();
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_len = len; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask
  task automatic run_cmd(input logic [25:0] a, input logic we, input logic [8:0] len);
    issue(a, we, len);
    for (int i = 0; i < 100 && ndone == 0; i++) @(negedge clk);
    chk("done_seen", 32'(ndone), 1);
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin rdat[i] = '0; wdat[i] = '0; wgap[i] = 0; end
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
    chk("rst_stb", 32'(bus.wb_stb_o), 0);
    chk("rst_cti", 32'(bus.wb_cti_o), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // single write, ack after two wait cycles
    wn = 1; wdat[0] = 32'hDEADBEEF; delay = 2;
    run_cmd(26'h100, 1'b1, 9'd1);
    chk("sw_beats", 32'(nb), 1);
    chk("sw_addr", 32'(b_addr[0]), 32'h100);
    chk("sw_cti", 32'(b_cti[0]), 3'b111);
    chk("sw_dat", b_dat[0], 32'hDEADBEEF);
    chk("sw_sel", 32'(b_sel[0]), 4'hF);
    chk("sw_stb_cycles", 32'(nstb), 3);
    chk("sw_err", 32'(lerr), 0);
    // read burst, ack every cycle
    wn = 0; delay = 0;
    rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h33; rdat[3] = 32'h44;
    run_cmd(26'h200, 1'b0, 9'd4);
    chk("rb_beats", 32'(nb), 4);
    chk("rb_rd_pulses", 32'(nr), 4);
    chk("rb_stb_cycles", 32'(nstb), 4);
    chk("rb_err", 32'(lerr), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rb_addr%0d", i), 32'(b_addr[i]), 32'h200 + 32'(4 * i));
      chk($sformatf("rb_cti%0d", i), 32'(b_cti[i]), (i == 3) ? 32'h7 : 32'h2);
      chk($sformatf("rb_data%0d", i), r_dat[i], 32'h11 * 32'(i + 1));
    end
    // write burst with a two-cycle data gap before beat 2
    wn = 3; wdat[0] = 32'hAA1; wdat[1] = 32'hBB2; wdat[2] = 32'hCC3;
    wgap[0] = 0; wgap[1] = 2; wgap[2] = 0;
    run_cmd(26'h300, 1'b1, 9'd3);
    chk("wg_beats", 32'(nb), 3);
    chk("wg_gap_cycles", 32'(ngap), 2);
    chk("wg_rd_pulses", 32'(nr), 0);
    chk("wg_dat0", b_dat[0], 32'hAA1);
    chk("wg_dat1", b_dat[1], 32'hBB2);
    chk("wg_dat2", b_dat[2], 32'hCC3);
    chk("wg_cti1", 32'(b_cti[1]), 3'b010);
    chk("wg_cti2", 32'(b_cti[2]), 3'b111);
    chk("wg_addr2", 32'(b_addr[2]), 32'h308);
    // timeout: slave never acks
    wn = 0; wgap[1] = 0; noack = 1'b1;
    run_cmd(26'h400, 1'b0, 9'd2);
    chk("to_stb_cycles", 32'(nstb), 15);
    chk("to_err", 32'(lerr), 1);
    chk("to_rd_pulses", 32'(nr), 0);
    chk("to_cyc_after", 32'(bus.wb_cyc_o), 0);
    noack = 1'b0;
    // address wrap at the top of the 26-bit space
    rdat[0] = 32'h5; rdat[1] = 32'h6;
    run_cmd(26'h3FFFFFC, 1'b0, 9'd2);
    chk("wr_addr0", 32'(b_addr[0]), 32'h3FFFFFC);
    chk("wr_addr1", 32'(b_addr[1]), 32'h0);
    chk("wr_data1", r_dat[1], 32'h6);
    // zero-length command is a no-op
    run_cmd(26'h500, 1'b0, 9'd0);
    chk("z_stb_cycles", 32'(nstb), 0);
    chk("z_err", 32'(lerr), 0);
    // async reset while beat 2 of 4 is pending
    delay = 1;
    issue(26'h600, 1'b0, 9'd4);
    for (int i = 0; i < 50 && nb < 1; i++) @(negedge clk);
    chk("ar_beat1_seen", 32'(nb), 1);
    @(posedge clk); #1;
    chk("ar_stb_before", 32'(bus.wb_stb_o), 1);
    rst = 1'b1;
    #1;
    chk("ar_cyc", 32'(bus.wb_cyc_o), 0);
    chk("ar_stb", 32'(bus.wb_stb_o), 0);
    chk("ar_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_cmd_ready", 32'(cmd_ready), 1);
    delay = 0; rdat[0] = 32'h77;
    run_cmd(26'h40, 1'b0, 9'd1);
    chk("ar_new_addr", 32'(b_addr[0]), 32'h40);
    chk("ar_new_rd", 32'(nr), 1);
    chk("ar_new_data", r_dat[0], 32'h77);
    chk("ar_new_err", 32'(lerr), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
